// File: rtl/uart_pkt_pkg.sv
// Shared types and constants for the UART packet parser.
// Holds the parser state encoding, the sync byte and default sizing.
package uart_pkt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_PAYLOAD,
        ST_CSUM,
        ST_HOLD
    } state_t;

    localparam logic [7:0] SYNC_BYTE              = 8'hA5;
    localparam int         DEFAULT_MAX_LEN        = 16;
    localparam int         DEFAULT_TIMEOUT_CYCLES = 100000;

endpackage

// File: rtl/uart_pkt_timer.sv
// Inter-byte idle timer: counts enabled cycles since the last clear.
// Signals expiry on the TIMEOUT_CYCLES-th consecutive idle cycle.
module uart_pkt_timer
    import uart_pkt_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count;

    // A byte arriving in the same cycle as the limit wins over expiry
    assign expired = enable && !clear && (count == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset || clear || !enable || expired) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_pkt_parser.sv
// Framed packet parser for a UART byte stream: SYNC, LEN, payload, XOR checksum.
// Holds a good packet until handshake; bytes arriving meanwhile are dropped and counted.
module uart_pkt_parser
    import uart_pkt_pkg::*;
#(
    parameter  int MAX_LEN        = DEFAULT_MAX_LEN,
    parameter  int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    localparam int LW             = $clog2(MAX_LEN + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    output logic [8*MAX_LEN-1:0] pkt_data,
    output logic [LW-1:0]        pkt_len,
    output logic                 pkt_valid,
    input  logic                 pkt_ready,
    output logic                 err_checksum,
    output logic                 err_len,
    output logic                 err_timeout,
    output logic [15:0]          drop_count
);

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_t        state;
    state_t        state_next;
    logic [LW-1:0] len_reg;
    logic [7:0]    csum_acc;
    logic          timer_active;
    logic          timer_expired;
    logic          err_checksum_next;
    logic          err_len_next;
    logic          err_timeout_next;
    logic          last_byte;

    assign timer_active = (state == ST_LEN) || (state == ST_PAYLOAD) || (state == ST_CSUM);
    assign last_byte    = (pkt_len == len_reg - 1'b1);
    assign pkt_valid    = (state == ST_HOLD);

    uart_pkt_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (rx_valid),
        .enable (timer_active),
        .expired(timer_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next        = state;
        err_checksum_next = 1'b0;
        err_len_next      = 1'b0;
        err_timeout_next  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rx_valid && rx_data == SYNC_BYTE) begin
                    state_next = ST_LEN;
                end
            end
            ST_LEN: begin
                if (rx_valid) begin
                    if (rx_data > MAX_LEN_B) begin
                        err_len_next = 1'b1;
                        state_next   = ST_IDLE;
                    end else if (rx_data == 8'h00) begin
                        state_next = ST_CSUM;
                    end else begin
                        state_next = ST_PAYLOAD;
                    end
                end else if (timer_expired) begin
                    err_timeout_next = 1'b1;
                    state_next       = ST_IDLE;
                end
            end
            ST_PAYLOAD: begin
                if (rx_valid) begin
                    if (last_byte) begin
                        state_next = ST_CSUM;
                    end
                end else if (timer_expired) begin
                    err_timeout_next = 1'b1;
                    state_next       = ST_IDLE;
                end
            end
            ST_CSUM: begin
                if (rx_valid) begin
                    if (rx_data == csum_acc) begin
                        state_next = ST_HOLD;
                    end else begin
                        err_checksum_next = 1'b1;
                        state_next        = ST_IDLE;
                    end
                end else if (timer_expired) begin
                    err_timeout_next = 1'b1;
                    state_next       = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (pkt_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // pkt_len doubles as the payload write index while a packet is assembled
    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_data     <= '0;
            pkt_len      <= '0;
            len_reg      <= '0;
            csum_acc     <= '0;
            drop_count   <= '0;
            err_checksum <= 1'b0;
            err_len      <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            err_checksum <= err_checksum_next;
            err_len      <= err_len_next;
            err_timeout  <= err_timeout_next;
            case (state)
                ST_IDLE: begin
                    if (rx_valid && rx_data == SYNC_BYTE) begin
                        pkt_data <= '0;
                        pkt_len  <= '0;
                        csum_acc <= '0;
                    end
                end
                ST_LEN: begin
                    if (rx_valid) begin
                        len_reg  <= rx_data[LW-1:0];
                        csum_acc <= rx_data;
                    end
                end
                ST_PAYLOAD: begin
                    if (rx_valid) begin
                        for (int i = 0; i < MAX_LEN; i++) begin
                            if (pkt_len == LW'(i)) begin
                                pkt_data[8*i +: 8] <= rx_data;
                            end
                        end
                        pkt_len  <= pkt_len + 1'b1;
                        csum_acc <= csum_acc ^ rx_data;
                    end
                end
                ST_HOLD: begin
                    if (rx_valid && drop_count != 16'hFFFF) begin
                        drop_count <= drop_count + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/uart_pkt_parser.md
UART_PKT_PARSER -- requirements
Module: uart_pkt_parser

Interface
REQ-001 SHALL have parameter MAX_LEN, default 16, maximum payload bytes per packet (1..255).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 100000, allowed inter-byte idle clk cycles inside a packet.
REQ-003 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port rx_data  input  8  received byte from the UART receiver.
REQ-006 SHALL have port rx_valid  input  1  one-cycle strobe, rx_data valid; no backpressure possible.
REQ-007 SHALL have port pkt_data  output  8*MAX_LEN  payload; byte i at bits [8i+7:8i], unused bytes zero.
REQ-008 SHALL have port pkt_len  output  $clog2(MAX_LEN+1)  payload byte count.
REQ-009 SHALL have port pkt_valid  output  1  packet available.
REQ-010 SHALL have port pkt_ready  input  1  consumer accepts packet.
REQ-011 SHALL have port err_checksum  output  1  one-cycle pulse, checksum mismatch.
REQ-012 SHALL have port err_len  output  1  one-cycle pulse, length byte > MAX_LEN.
REQ-013 SHALL have port err_timeout  output  1  one-cycle pulse, inter-byte timeout.
REQ-014 SHALL have port drop_count  output  16  saturating count of bytes discarded while holding a packet.

Function
REQ-015 SHALL frame packets as: SYNC 0xA5, LEN, LEN payload bytes, CSUM = XOR of LEN and all payload bytes.
REQ-016 SHALL implement states IDLE, LEN, PAYLOAD, CSUM, HOLD.
REQ-017 IDLE: ignore non-0xA5 bytes; on 0xA5 go to LEN.
REQ-018 LEN: LEN > MAX_LEN -> err_len pulse, go to IDLE; LEN == 0 -> CSUM; otherwise -> PAYLOAD.
REQ-019 PAYLOAD: store each byte at the next index; after byte LEN-1 go to CSUM.
REQ-020 CSUM: match -> HOLD with pkt_valid=1 in the next cycle; mismatch -> err_checksum pulse, go to IDLE.
REQ-021 In HOLD, pkt_data and pkt_len SHALL be stable until handshake; pkt_valid && pkt_ready -> IDLE next cycle.
REQ-022 A byte arriving in HOLD, including the handshake cycle, SHALL be dropped and counted in drop_count, saturating at 0xFFFF.
REQ-023 In LEN/PAYLOAD/CSUM, the idle counter SHALL clear on every rx_valid; at TIMEOUT_CYCLES-1 without a byte -> err_timeout pulse, go to IDLE.
REQ-024 The payload buffer SHALL clear on entry to LEN, so stale bytes never appear in pkt_data.
REQ-025 A 0xA5 byte received in LEN/PAYLOAD/CSUM SHALL be treated as data, not as a resync.
REQ-026 Error pulses SHALL be mutually exclusive and last exactly one cycle.

Reset
REQ-027 Reset SHALL drive: state IDLE, pkt_valid 0, pkt_data 0, pkt_len 0, all err_* 0, drop_count 0, timer 0.
REQ-028 Reset asserted mid-packet or in HOLD SHALL abandon the packet with no error pulse; rx_valid SHALL be ignored while reset is high.

Structure
REQ-029 Package uart_pkt_pkg SHALL hold the state enum, SYNC_BYTE = 8'hA5, and the default MAX_LEN/TIMEOUT_CYCLES constants.
REQ-030 The inter-byte timeout counter SHALL be a sub-module uart_pkt_timer with ports clk, reset, clear, enable, expired.

Verification
REQ-031 Bytes A5 03 01 02 03 03 -> pkt_valid with pkt_len=3, pkt_data[23:0]=0x030201, no error pulses.
REQ-032 Bytes 00 A5 00 00 -> pkt_valid, pkt_len=0, pkt_data=0; the leading 00 is ignored.
REQ-033 Bytes A5 02 11 22 FF (expected CSUM 0x31) -> single err_checksum pulse, pkt_valid stays 0, state returns to IDLE.
REQ-034 Bytes A5 11 (17 > MAX_LEN) -> err_len pulse; a following A5 01 7E 7F -> valid packet, pkt_data[7:0]=0x7E.
REQ-035 Bytes A5 03 01, then TIMEOUT_CYCLES idle cycles -> exactly one err_timeout pulse; a new packet then parses correctly.
REQ-036 pkt_ready=0 while holding the REQ-031 packet, then 6 more bytes sent -> drop_count=6 and the held packet is unchanged; pkt_ready=1 -> handshake, then IDLE.
